// File: rtl/bcd_to_bin_pkg.sv
// Shared definitions for the BCD-to-binary converter: FSM encodings and the
// largest legal BCD digit value.
package bcd_to_bin_pkg;

  // Conversion sequencer states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  // Largest value a single BCD digit may legally hold
  localparam logic [3:0] DIGIT_MAX = 4'd9;

endpackage

// File: rtl/bcd_digit_acc.sv
// One Horner step of BCD-to-binary conversion: acc*10 + digit, built from
// two shifts and adds so no multiplier is inferred.
// Optional feature macro: BCD_TO_BIN_CHECK_EN adds the digit>9 flag output.
module bcd_digit_acc #(
  parameter int ACC_W = 18
) (
  input  logic [ACC_W-1:0] acc,
  input  logic [3:0]       digit,
`ifdef BCD_TO_BIN_CHECK_EN
  output logic             digit_bad,
`endif
  output logic [ACC_W-1:0] acc_next
);
  import bcd_to_bin_pkg::*;

  // acc*8 + acc*2 + digit; carries beyond ACC_W are intentionally dropped
  assign acc_next = (acc << 3) + (acc << 1) + {{(ACC_W-4){1'b0}}, digit};

`ifdef BCD_TO_BIN_CHECK_EN
  // A nibble above 9 is not a valid BCD digit
  assign digit_bad = (digit > DIGIT_MAX);
`endif

endmodule

// File: rtl/bcd_to_bin.sv
// Serial packed-BCD to binary converter. One digit is folded into the
// accumulator per cycle, most significant digit first, with a valid/ready
// handshake on both sides. No operand is buffered while busy.
// Optional feature macro: BCD_TO_BIN_CHECK_EN enables the sticky invalid-digit
// error flag; without it err is tied low.
module bcd_to_bin
  import bcd_to_bin_pkg::*;
#(
  parameter int NDIGITS = 4,
  parameter int BIN_W   = 14
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [4*NDIGITS-1:0]   bcd_in,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [BIN_W-1:0]       bin_out,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   err
);

  localparam int SR_W  = 4 * NDIGITS;
  localparam int ACC_W = BIN_W + 4;
  localparam int CNT_W = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NDIGITS - 1);

  state_t             state_reg;
  state_t             state_next;
  logic [SR_W-1:0]    shift_reg;
  logic [ACC_W-1:0]   acc_reg;
  logic [ACC_W-1:0]   acc_next;
  logic [CNT_W-1:0]   cnt_reg;
  logic [3:0]         cur_digit;
  logic               last_digit;

  // The digit being consumed always sits in the top nibble of the shifter
  assign cur_digit  = shift_reg[SR_W-1 -: 4];
  assign last_digit = (cnt_reg == LAST_CNT);

`ifdef BCD_TO_BIN_CHECK_EN
  logic digit_bad;
  logic err_reg;
`endif

  bcd_digit_acc #(
    .ACC_W(ACC_W)
  ) u_digit_acc (
    .acc      (acc_reg),
    .digit    (cur_digit),
`ifdef BCD_TO_BIN_CHECK_EN
    .digit_bad(digit_bad),
`endif
    .acc_next (acc_next)
  );

  // Next-state decode: accept, run NDIGITS steps, then hold until consumed
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (in_valid)   state_next = CONV;
      CONV:    if (last_digit) state_next = DONE;
      DONE:    if (out_ready)  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Operand capture, digit shifting and accumulation
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_reg <= '0;
      acc_reg   <= '0;
      cnt_reg   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            shift_reg <= bcd_in;
            acc_reg   <= '0;
            cnt_reg   <= '0;
          end
        end
        CONV: begin
          acc_reg   <= acc_next;
          shift_reg <= shift_reg << 4;
          cnt_reg   <= cnt_reg + 1'b1;
        end
        default: begin
          // DONE: everything held so the result stays stable
        end
      endcase
    end
  end

`ifdef BCD_TO_BIN_CHECK_EN
  // Sticky invalid-digit flag, cleared when a new operand is accepted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_reg <= 1'b0;
    end else if (state_reg == IDLE && in_valid) begin
      err_reg <= 1'b0;
    end else if (state_reg == CONV) begin
      err_reg <= err_reg | digit_bad;
    end
  end
  assign err = err_reg;
`else
  assign err = 1'b0;
`endif

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);
  assign bin_out   = acc_reg[BIN_W-1:0];

endmodule

// File: tb/tb_bcd_to_bin.sv
// Self-checking bench for bcd_to_bin: directed scenarios followed by random
// traffic, all checked against a decimal-arithmetic model of the handshake.
module tb_bcd_to_bin;

  localparam int NDIGITS = 4;
  localparam int BIN_W   = 14;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [4*NDIGITS-1:0] bcd_in;
  logic                 in_valid;
  logic                 in_ready;
  logic [BIN_W-1:0]     bin_out;
  logic                 out_valid;
  logic                 out_ready;
  logic                 err;

  bcd_to_bin #(
    .NDIGITS(NDIGITS),
    .BIN_W  (BIN_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bcd_in   (bcd_in),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .bin_out  (bin_out),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .err      (err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Decimal value of a packed BCD word: sum of digit * 10^position
  function automatic int ref_value(input logic [4*NDIGITS-1:0] b);
    int v = 0;
    int p = 1;
    for (int i = 0; i < NDIGITS; i++) begin
      v += int'(b[4*i +: 4]) * p;
      p *= 10;
    end
    return v % (1 << BIN_W);
  endfunction

  function automatic int ref_err(input logic [4*NDIGITS-1:0] b);
    int e = 0;
`ifdef BCD_TO_BIN_CHECK_EN
    for (int i = 0; i < NDIGITS; i++)
      if (b[4*i +: 4] > 4'd9) e = 1;
`endif
    return e;
  endfunction

  // Behavioural model: one outstanding operand, result visible NDIGITS edges
  // after acceptance, released on an out_ready handshake.
  bit                   m_pending = 1'b0;
  int                   m_val = 0;
  int                   m_err = 0;
  int                   m_valid_at = 0;
  int                   cyc = 0;
  int                   txn = 0;
  logic [4*NDIGITS-1:0] m_bcd = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pending = 1'b0;
    end else begin
      if (m_pending && cyc >= m_valid_at && out_ready) begin
        m_pending = 1'b0;
        txn++;
        $display("txn %0d: bcd=%h bin_out=%0d err=%0d", txn, m_bcd, bin_out, err);
      end else if (!m_pending && in_valid) begin
        m_pending  = 1'b1;
        m_bcd      = bcd_in;
        m_val      = ref_value(bcd_in);
        m_err      = ref_err(bcd_in);
        m_valid_at = cyc + 1 + NDIGITS;
      end
      cyc++;
    end
  end

  // Every-cycle comparison of the handshake and result against the model
  always @(negedge clk) begin
    if (!rst) begin
      bit exp_ov;
      exp_ov = m_pending && (cyc >= m_valid_at);
      check("in_ready", int'(in_ready), int'(!m_pending));
      check("out_valid", int'(out_valid), int'(exp_ov));
      if (exp_ov) begin
        check("bin_out", int'(bin_out), m_val);
        check("err", int'(err), m_err);
      end
    end
  end

  // One directed conversion; hold>0 stalls the consumer for that many cycles
  // and injects an extra in_valid that must be ignored.
  task automatic do_op(input logic [15:0] b, input int exp_bin, input int exp_err,
                       input int hold, input string tag);
    int lat;
    @(negedge clk);
    bcd_in    = b;
    in_valid  = 1'b1;
    out_ready = (hold == 0);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    // out_valid rises after edge k+NDIGITS, so edge k+NDIGITS+1 samples it
    check({tag, " latency"}, lat, NDIGITS);
    check({tag, " bin_out"}, int'(bin_out), exp_bin);
    check({tag, " err"}, int'(err), exp_err);
    for (int i = 0; i < hold; i++) begin
      if (i == 3) begin
        bcd_in   = 16'h9999;
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      check({tag, " held bin_out"}, int'(bin_out), exp_bin);
      check({tag, " held out_valid"}, int'(out_valid), 1);
      check({tag, " held in_ready"}, int'(in_ready), 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check({tag, " out_valid after handshake"}, int'(out_valid), 0);
    check({tag, " in_ready after handshake"}, int'(in_ready), 1);
    out_ready = 1'b0;
  endtask

  function automatic logic [15:0] rand_bcd();
    logic [15:0] b;
    for (int i = 0; i < NDIGITS; i++) begin
      if ($urandom_range(0, 7) == 0) b[4*i +: 4] = 4'($urandom_range(10, 15));
      else                           b[4*i +: 4] = 4'($urandom_range(0, 9));
    end
    return b;
  endfunction

  int exp_12a4_err;

  initial begin
`ifdef BCD_TO_BIN_CHECK_EN
    exp_12a4_err = 1;
`else
    exp_12a4_err = 0;
`endif
    rst       = 1'b1;
    bcd_in    = '0;
    in_valid  = 1'b0;
    out_ready = 1'b0;

    // Hand-computed values pinning the model
    check("model 1234", ref_value(16'h1234), 1234);
    check("model 12A4", ref_value(16'h12A4), 1304);

    repeat (2) @(negedge clk);
    check("reset in_ready", int'(in_ready), 1);
    check("reset out_valid", int'(out_valid), 0);
    check("reset bin_out", int'(bin_out), 0);
    check("reset err", int'(err), 0);
    #2 rst = 1'b0;

    do_op(16'h0000, 0,    0,            0,  "zero");
    do_op(16'h1234, 1234, 0,            0,  "1234");
    do_op(16'h9999, 9999, 0,            0,  "9999");
    do_op(16'h0567, 567,  0,            10, "0567 stall");
    do_op(16'h12A4, 1304, exp_12a4_err, 0,  "12A4");

    // Abort during the second CONV cycle
    @(negedge clk);
    bcd_in   = 16'h1234;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort out_valid", int'(out_valid), 0);
    check("abort bin_out", int'(bin_out), 0);
    check("abort in_ready", int'(in_ready), 1);
    check("abort err", int'(err), 0);
    @(negedge clk);
    #2 rst = 1'b0;
    do_op(16'h0042, 42, 0, 0, "0042");

    // Random traffic with back-pressure and ignored in_valid while busy
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      in_valid  = 1'($urandom_range(0, 1));
      bcd_in    = rand_bcd();
      out_ready = ($urandom_range(0, 3) != 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (12) @(negedge clk);
    check("random transactions seen", int'(txn > 100), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bcd_to_bin.md
BCD_TO_BIN -- requirements
Module: bcd_to_bin

Interface
REQ-001 Parameter NDIGITS, default 4: number of packed BCD digits accepted (legal range 1..6).
REQ-002 Parameter BIN_W, default 14: binary result width; SHALL be at least ceil(log2(10^NDIGITS)).
REQ-003 clk  in  1  single system clock; all state SHALL update on the rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 bcd_in  in  4*NDIGITS  packed BCD operand; MSD in the top nibble.
REQ-006 in_valid  in  1  operand on bcd_in is valid.
REQ-007 in_ready  out  1  block can accept an operand.
REQ-008 bin_out  out  BIN_W  binary result.
REQ-009 out_valid  out  1  bin_out (and err) valid.
REQ-010 out_ready  in  1  consumer accepts the result.
REQ-011 err  out  1  at least one digit of the operand was greater than 9 (see Configuration).

Function
REQ-012 FSM states SHALL be IDLE, CONV and DONE.
REQ-013 IDLE: in_ready=1. On in_valid=1, at the rising edge the block SHALL:
  - capture bcd_in into an internal shift register;
  - clear the accumulator and digit counter;
  - go to CONV.
REQ-014 CONV: in_ready=0. Each cycle SHALL compute acc <= acc*10 + current digit, MSD first, using the form (acc<<3)+(acc<<1)+digit with no multiplier.
REQ-015 CONV SHALL last exactly NDIGITS cycles, then go to DONE.
REQ-016 Latency: with in_valid sampled at edge k, out_valid SHALL be 1 from edge k+NDIGITS+1.
REQ-017 DONE: out_valid=1; bin_out and err SHALL be held stable until out_ready=1 is sampled. On that edge the FSM SHALL return to IDLE.
REQ-018 in_ready SHALL be 0 in CONV and DONE; in_valid is ignored in those states. No operand is buffered.
REQ-019 bin_out SHALL be truncated to BIN_W bits. With a legal BIN_W no overflow occurs, and 10^NDIGITS-1 SHALL convert exactly.
REQ-020 Accumulator arithmetic SHALL be carried at BIN_W+4 bits internally, then truncated on output.
REQ-021 A new operand SHALL be accepted no sooner than the cycle after the DONE handshake. Maximum throughput is one result per NDIGITS+2 cycles.

Reset
REQ-022 rst=1 SHALL asynchronously force:
  - FSM to IDLE;
  - bin_out, accumulator, shift register and counter to 0;
  - out_valid=0, err=0, in_ready=1.
REQ-023 Reset asserted mid-CONV or mid-DONE SHALL abort the conversion. No partial result is presented.
REQ-024 After rst deasserts, the first operand SHALL be accepted on the first edge with in_valid=1.

Configuration
REQ-025 Macro BCD_TO_BIN_CHECK_EN:
  - Defined: each digit consumed in CONV SHALL be compared against 9. err SHALL be the sticky OR of (digit>9) across the operand and is valid with out_valid. The arithmetic result is still produced.
  - Undefined: no comparison logic SHALL exist and err SHALL be tied to 0.

Structure
REQ-026 A shared package/include file SHALL hold:
  - FSM state encodings (IDLE=2'd0, CONV=2'd1, DONE=2'd2);
  - the constant DIGIT_MAX=4'd9.
REQ-027 One combinational sub-module bcd_digit_acc SHALL implement acc*10+digit and the digit>9 flag. It is instantiated once in bcd_to_bin.

Verification
REQ-028 The bench SHALL cover these directed scenarios (NDIGITS=4, BIN_W=14):
  - Reset then bcd_in=16'h0000, in_valid pulse -> bin_out=0, out_valid at edge k+5, err=0.
  - bcd_in=16'h1234, out_ready=1 -> bin_out=1234 (14'h04D2), out_valid high exactly one cycle, in_ready=1 on the following cycle.
  - bcd_in=16'h9999 -> bin_out=9999 (14'h270F), no truncation.
  - bcd_in=16'h0567, out_ready held 0 for 10 cycles -> bin_out=567 held stable, in_ready=0 throughout, a second in_valid is ignored.
  - With BCD_TO_BIN_CHECK_EN defined, bcd_in=16'h12A4 -> err=1 alongside out_valid. Without the macro -> err=0.
  - rst pulsed during the 2nd CONV cycle -> out_valid=0, bin_out=0, in_ready=1 immediately. The next operand 16'h0042 converts to 42.
